gpmc_pwm_bank: RTL and testbench

//  Register-mapped 4-channel PWM generator on the system clock. It sits directly downstream of the GPMC

---
 rtl/gpmc_pwm_bank.sv | 151 +++++++++++++++
 tb/tb_gpmc_pwm_bank.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gpmc_pwm_bank.sv
// Register-mapped PWM bank behind the GPMC bridge: CTRL/PRESCALE/PERIOD/DUTY/STATUS registers,
// shadowed PERIOD/DUTY that load at period wrap, and registered PWM outputs.
module gpmc_pwm_bank #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rd_valid,
    output logic [NUM_CH-1:0]     pwm_out,
    output logic                  period_irq
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL     = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PRESCALE = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_PERIOD   = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DUTY0    = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] ADDR_STATUS   = ADDR_WIDTH'(7);
    localparam logic [15:0]           STATUS_MAX    = 16'hFFFF;

    logic [DATA_WIDTH-1:0] ctrl_r;
    logic [DATA_WIDTH-1:0] prescale_r;
    logic [DATA_WIDTH-1:0] period_pend_r;
    logic [DATA_WIDTH-1:0] period_act_r;
    logic [DATA_WIDTH-1:0] duty_pend_r [NUM_CH];
    logic [DATA_WIDTH-1:0] duty_act_r  [NUM_CH];
    logic [DATA_WIDTH-1:0] pre_cnt_r;
    logic [DATA_WIDTH-1:0] cnt_r;
    logic [15:0]           status_r;

    logic                  run_s;
    logic [NUM_CH-1:0]     ch_en_s;
    logic                  tick_s;
    logic                  wrap_s;
    logic                  in_duty_s;
    logic [ADDR_WIDTH-1:0] duty_off_s;
    logic [CH_W-1:0]       duty_idx_s;
    logic                  wr_ctrl_s;
    logic                  wr_prescale_s;
    logic                  wr_period_s;
    logic                  wr_duty_s;
    logic                  wr_status_s;
    logic [DATA_WIDTH-1:0] rd_mux_s;

    assign run_s   = ctrl_r[0];
    assign ch_en_s = ctrl_r[4 +: NUM_CH];
    assign tick_s  = run_s && (pre_cnt_r == prescale_r);
    assign wrap_s  = tick_s && (cnt_r == period_act_r);

    assign in_duty_s  = (addr >= ADDR_DUTY0) && (addr < (ADDR_DUTY0 + ADDR_WIDTH'(NUM_CH)));
    assign duty_off_s = addr - ADDR_DUTY0;
    assign duty_idx_s = duty_off_s[CH_W-1:0];

    assign wr_ctrl_s     = wr_en && (addr == ADDR_CTRL);
    assign wr_prescale_s = wr_en && (addr == ADDR_PRESCALE);
    assign wr_period_s   = wr_en && (addr == ADDR_PERIOD);
    assign wr_duty_s     = wr_en && in_duty_s;
    assign wr_status_s   = wr_en && (addr == ADDR_STATUS);

    // Read-back mux; PERIOD/DUTY return the pending (host-visible) copies
    always_comb begin
        rd_mux_s = '0;
        case (addr)
            ADDR_CTRL:     rd_mux_s = ctrl_r;
            ADDR_PRESCALE: rd_mux_s = prescale_r;
            ADDR_PERIOD:   rd_mux_s = period_pend_r;
            ADDR_STATUS:   rd_mux_s = DATA_WIDTH'(status_r);
            default:       rd_mux_s = in_duty_s ? duty_pend_r[duty_idx_s] : '0;
        endcase
    end

    // Host-writable configuration and pending shadow registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_r        <= '0;
            prescale_r    <= '0;
            period_pend_r <= '0;
            for (int i = 0; i < NUM_CH; i++) duty_pend_r[i] <= '0;
        end else begin
            if (wr_ctrl_s)     ctrl_r                  <= wdata;
            if (wr_prescale_s) prescale_r              <= wdata;
            if (wr_period_s)   period_pend_r           <= wdata;
            if (wr_duty_s)     duty_pend_r[duty_idx_s] <= wdata;
        end
    end

    // Active copies follow pending while stopped, otherwise only at wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            period_act_r <= '0;
            for (int i = 0; i < NUM_CH; i++) duty_act_r[i] <= '0;
        end else if (!run_s || wrap_s) begin
            period_act_r <= period_pend_r;
            for (int i = 0; i < NUM_CH; i++) duty_act_r[i] <= duty_pend_r[i];
        end
    end

    // Prescaler and period counter, both parked at zero while stopped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt_r <= '0;
            cnt_r     <= '0;
        end else if (!run_s) begin
            pre_cnt_r <= '0;
            cnt_r     <= '0;
        end else begin
            if (wr_prescale_s || tick_s) pre_cnt_r <= '0;
            else                         pre_cnt_r <= pre_cnt_r + DATA_WIDTH'(1);
            if (wrap_s)      cnt_r <= '0;
            else if (tick_s) cnt_r <= cnt_r + DATA_WIDTH'(1);
        end
    end

    // Saturating wrap counter; a host write on the wrap clock still clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                      status_r <= 16'h0000;
        else if (wr_status_s)                         status_r <= 16'h0000;
        else if (wrap_s && (status_r != STATUS_MAX))  status_r <= status_r + 16'h0001;
    end

    // Registered PWM pins and wrap pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out    <= '0;
            period_irq <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                pwm_out[i] <= run_s & ch_en_s[i] & (cnt_r < duty_act_r[i]);
            period_irq <= wrap_s;
        end
    end

    // Registered read port; rdata holds between reads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata    <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rdata <= rd_mux_s;
        end
    end

endmodule

// File: tb/tb_gpmc_pwm_bank.sv
// Directed bench for gpmc_pwm_bank: read results go through an expected-value queue checked
// whenever rd_valid pulses; PWM/IRQ waveforms are checked per clock against closed-form timing.
module tb_gpmc_pwm_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [3:0]  addr = 4'd0;
    logic [15:0] wdata = 16'd0;
    logic [15:0] rdata;
    logic        rd_valid;
    logic [3:0]  pwm_out;
    logic        period_irq;

    int          tests = 0;
    int          fails = 0;
    int          k = 0;
    logic [15:0] exp_q [$];

    gpmc_pwm_bank dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
        .rdata(rdata), .rd_valid(rd_valid), .pwm_out(pwm_out), .period_irq(period_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every read result is compared against the value queued when it was issued
    always @(negedge clk) begin
        if (rd_valid === 1'b1) begin
            if (exp_q.size() == 0) chk("rd_unexpected", 32'(rd_valid), 32'd0);
            else                   chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
        end
    end

    task automatic idle();
        @(negedge clk); k++;
    endtask

    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk); wr_en = 1'b0; k++;
    endtask

    task automatic rd(input logic [3:0] a, input logic [15:0] e);
        rd_en = 1'b1; addr = a; exp_q.push_back(e);
        @(negedge clk); rd_en = 1'b0; k++;
    endtask

    task automatic wr_rd(input logic [3:0] a, input logic [15:0] d, input logic [15:0] e);
        wr_en = 1'b1; rd_en = 1'b1; addr = a; wdata = d; exp_q.push_back(e);
        @(negedge clk); wr_en = 1'b0; rd_en = 1'b0; k++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk); rst = 1'b0; k = 0;
    endtask

    task automatic chk_pwm(input logic [3:0] e, input logic ei);
        chk($sformatf("pwm k=%0d", k), 32'(pwm_out), 32'(e));
        chk($sformatf("irq k=%0d", k), 32'(period_irq), 32'(ei));
    endtask

    task automatic start_basic(input logic [15:0] duty0);
        do_reset();
        wr(4'd2, 16'd9); wr(4'd3, duty0); wr(4'd0, 16'h0011); k = 0;
    endtask

    initial begin
        logic ep;
        // Reset with random bus traffic
        repeat (4) begin
            @(negedge clk);
            wr_en = 1'($urandom); rd_en = 1'($urandom);
            addr = 4'($urandom); wdata = 16'($urandom);
            chk("rst_pwm", 32'(pwm_out), 32'd0);
            chk("rst_rdv", 32'(rd_valid), 32'd0);
            chk("rst_rdata", 32'(rdata), 32'd0);
            chk("rst_irq", 32'(period_irq), 32'd0);
        end
        wr_en = 1'b0; rd_en = 1'b0;
        @(negedge clk); rst = 1'b0;
        for (int a = 0; a < 8; a++) rd(4'(a), 16'd0);

        // Basic PWM: 3 high / 7 low, irq every 10 clks
        start_basic(16'd3);
        repeat (30) begin
            idle(); ep = ((k - 1) % 10) < 3;
            chk_pwm({3'b000, ep}, (k % 10) == 0);
        end
        rd(4'd7, 16'd3); rd(4'd2, 16'd9); rd(4'd3, 16'd3); rd(4'd0, 16'h0011);

        // Extremes: DUTY=0 constant low, DUTY>PERIOD constant high
        do_reset();
        wr(4'd2, 16'd9); wr(4'd4, 16'd0); wr(4'd5, 16'd10); wr(4'd0, 16'h0071); k = 0;
        repeat (20) begin
            idle(); chk_pwm(4'b0100, (k % 10) == 0);
        end

        // PRESCALE=2 stretches each count to 3 clks, period to 30 clks
        do_reset();
        wr(4'd1, 16'd2); wr(4'd2, 16'd9); wr(4'd3, 16'd3); wr(4'd0, 16'h0011); k = 0;
        repeat (60) begin
            idle(); ep = (((k - 1) / 3) % 10) < 3;
            chk_pwm({3'b000, ep}, (k % 30) == 0);
        end

        // Shadowing: DUTY0 rewritten mid-period applies from the next period
        start_basic(16'd3);
        idle(); chk_pwm(4'b0001, 1'b0);
        wr(4'd3, 16'd7);
        rd(4'd3, 16'd7);
        repeat (27) begin
            idle(); ep = ((k - 1) % 10) < ((k <= 10) ? 3 : 7);
            chk_pwm({3'b000, ep}, (k % 10) == 0);
        end

        // Collisions: DUTY write on the wrap clock, STATUS clear on wrap, wr+rd same clock
        start_basic(16'd3);
        repeat (9) begin
            idle(); ep = ((k - 1) % 10) < 3;
            chk_pwm({3'b000, ep}, 1'b0);
        end
        wr(4'd3, 16'd5);
        chk_pwm(4'b0000, 1'b1);
        repeat (29) begin
            idle(); ep = ((k - 1) % 10) < ((k <= 20) ? 3 : 5);
            chk_pwm({3'b000, ep}, (k % 10) == 0);
        end
        wr(4'd7, 16'h1234);
        chk("irq_wrap40", 32'(period_irq), 32'd1);
        rd(4'd7, 16'd0);
        wr_rd(4'd2, 16'd20, 16'd9);
        rd(4'd2, 16'd20);
        idle();
        chk("rdata_hold", 32'(rdata), 32'd20);
        chk("rdv_low", 32'(rd_valid), 32'd0);

        // Run toggle: stop mid-period, no irq while stopped, restart from cnt=0
        start_basic(16'd3);
        idle(); idle();
        chk_pwm(4'b0001, 1'b0);
        wr(4'd0, 16'h0010);
        repeat (12) begin
            idle(); chk_pwm(4'b0000, 1'b0);
        end
        wr(4'd0, 16'h0011); k = 0;
        repeat (11) begin
            idle(); ep = ((k - 1) % 10) < 3;
            chk_pwm({3'b000, ep}, k == 10);
        end
        rd(4'd2, 16'd9);
        chk("pwm_pre_rst", 32'(pwm_out), 32'd1);

        // Asynchronous reset mid-pulse
        #2 rst = 1'b1;
        #1;
        chk("arst_pwm", 32'(pwm_out), 32'd0);
        chk("arst_rdv", 32'(rd_valid), 32'd0);
        chk("arst_rdata", 32'(rdata), 32'd0);
        chk("arst_irq", 32'(period_irq), 32'd0);
        @(negedge clk); rst = 1'b0;
        repeat (3) begin
            idle(); chk_pwm(4'b0000, 1'b0);
        end
        for (int a = 0; a < 8; a++) rd(4'(a), 16'd0);
        wr(4'd12, 16'hFFFF);
        rd(4'd12, 16'd0);
        idle(); idle();
        chk("rd_outstanding", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
